// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and stall controller for the 5-stage core.
//   Detects load-use hazards between ID and EX. Freezes every stage while a
//   data-memory access is outstanding. Flushes IF/ID on taken branches.
//   Keeps saturating event counters and a sticky memory-timeout flag.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   ID_rs1_i, ID_rs2_i      source registers of the instruction in ID
//   EX_MemRead_i, EX_rd_i   load flag and destination of the instruction in EX
//   branch_taken_i          branch in ID resolved taken
//   mem_req_i, mem_ack_i    data-memory request in flight / completion
//   PCWrite_o .. MEMWB_stall_o  combinational pipeline controls
//   mem_err_o               sticky timeout flag
//   bubble_cnt_o, freeze_cnt_o, flush_cnt_o  saturating event counters
module hazard_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       ID_rs1_i,
  input  logic [4:0]       ID_rs2_i,
  input  logic             EX_MemRead_i,
  input  logic [4:0]       EX_rd_i,
  input  logic             branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             PCWrite_o,
  output logic             IFID_stall_o,
  output logic             IFID_flush_o,
  output logic             NoOp_o,
  output logic             IDEX_stall_o,
  output logic             EXMEM_stall_o,
  output logic             MEMWB_stall_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] bubble_cnt_o,
  output logic [CNT_W-1:0] freeze_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic {RUN, MEMWAIT} state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              freeze;
  logic              loaduse;

  // Reset gates the freeze so every output goes idle while rst_i is high.
  always_comb begin
    freeze = 1'b0;
    if (!rst_i) begin
      if (state == RUN) freeze = mem_req_i & ~mem_ack_i;
      else              freeze = ~mem_ack_i;
    end
  end

  assign loaduse = EX_MemRead_i && (EX_rd_i != 5'd0) &&
                   ((EX_rd_i == ID_rs1_i) || (EX_rd_i == ID_rs2_i));

  always_comb begin
    PCWrite_o     = 1'b1;
    IFID_stall_o  = 1'b0;
    IFID_flush_o  = 1'b0;
    NoOp_o        = 1'b0;
    IDEX_stall_o  = 1'b0;
    EXMEM_stall_o = 1'b0;
    MEMWB_stall_o = 1'b0;
    if (rst_i) begin
      PCWrite_o = 1'b1;
    end else if (freeze) begin
      PCWrite_o     = 1'b0;
      IFID_stall_o  = 1'b1;
      IDEX_stall_o  = 1'b1;
      EXMEM_stall_o = 1'b1;
      MEMWB_stall_o = 1'b1;
    end else if (loaduse) begin
      PCWrite_o    = 1'b0;
      IFID_stall_o = 1'b1;
      NoOp_o       = 1'b1;
    end else if (branch_taken_i) begin
      IFID_flush_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= RUN;
      wait_cnt     <= '0;
      mem_err_o    <= 1'b0;
      bubble_cnt_o <= '0;
      freeze_cnt_o <= '0;
      flush_cnt_o  <= '0;
    end else begin
      case (state)
        RUN:     if (mem_req_i && !mem_ack_i) state <= MEMWAIT;
        MEMWAIT: if (mem_ack_i)               state <= RUN;
        default: state <= RUN;
      endcase

      if (freeze) begin
        if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
        // Edge closing the TIMEOUT-th consecutive freeze cycle.
        if (wait_cnt == WAIT_LAST) mem_err_o <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end

      if (NoOp_o && (bubble_cnt_o != '1))       bubble_cnt_o <= bubble_cnt_o + 1'b1;
      if (freeze && (freeze_cnt_o != '1))       freeze_cnt_o <= freeze_cnt_o + 1'b1;
      if (IFID_flush_o && (flush_cnt_o != '1))  flush_cnt_o  <= flush_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  localparam int TO   = 4;
  localparam int CW   = 3;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk_i = 1'b0;
  logic          rst_i, EX_MemRead_i, branch_taken_i, mem_req_i, mem_ack_i;
  logic [4:0]    ID_rs1_i, ID_rs2_i, EX_rd_i;
  logic          PCWrite_o, IFID_stall_o, IFID_flush_o, NoOp_o;
  logic          IDEX_stall_o, EXMEM_stall_o, MEMWB_stall_o, mem_err_o;
  logic [CW-1:0] bubble_cnt_o, freeze_cnt_o, flush_cnt_o;

  hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ID_rs1_i(ID_rs1_i), .ID_rs2_i(ID_rs2_i),
    .EX_MemRead_i(EX_MemRead_i), .EX_rd_i(EX_rd_i),
    .branch_taken_i(branch_taken_i),
    .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
    .PCWrite_o(PCWrite_o), .IFID_stall_o(IFID_stall_o), .IFID_flush_o(IFID_flush_o),
    .NoOp_o(NoOp_o), .IDEX_stall_o(IDEX_stall_o), .EXMEM_stall_o(EXMEM_stall_o),
    .MEMWB_stall_o(MEMWB_stall_o), .mem_err_o(mem_err_o),
    .bubble_cnt_o(bubble_cnt_o), .freeze_cnt_o(freeze_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  // Reference model: access-outstanding flag, length of current freeze run,
  // sticky error and plain integer event counts clipped at MAXC.
  bit m_waiting;
  int m_run;
  bit m_err;
  int m_bub, m_frz, m_fl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check combinational outputs and current state,
  // then advance the model across the rising edge.
  task automatic cyc(input logic rst, input logic mrq, input logic ack,
                     input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic br);
    bit f, lu;
    logic [6:0] exp_ctl;
    rst_i = rst; mem_req_i = mrq; mem_ack_i = ack; EX_MemRead_i = mr;
    EX_rd_i = rd; ID_rs1_i = rs1; ID_rs2_i = rs2; branch_taken_i = br;
    #1;
    if (rst) begin
      m_waiting = 0; m_run = 0; m_err = 0; m_bub = 0; m_frz = 0; m_fl = 0;
    end
    f  = !rst && (m_waiting ? !ack : (mrq && !ack));
    lu = mr && (rd != 0) && (rd == rs1 || rd == rs2);
    // {PCWrite, IFID_stall, IFID_flush, NoOp, IDEX_stall, EXMEM_stall, MEMWB_stall}
    if (rst)     exp_ctl = 7'b1000000;
    else if (f)  exp_ctl = 7'b0100111;
    else if (lu) exp_ctl = 7'b0101000;
    else if (br) exp_ctl = 7'b1010000;
    else         exp_ctl = 7'b1000000;
    chk("ctl", {25'd0, PCWrite_o, IFID_stall_o, IFID_flush_o, NoOp_o,
                IDEX_stall_o, EXMEM_stall_o, MEMWB_stall_o}, {25'd0, exp_ctl});
    chk("mem_err", {31'd0, mem_err_o}, {31'd0, m_err});
    chk("bubble_cnt", {29'd0, bubble_cnt_o}, m_bub);
    chk("freeze_cnt", {29'd0, freeze_cnt_o}, m_frz);
    chk("flush_cnt",  {29'd0, flush_cnt_o},  m_fl);
    @(posedge clk_i);
    if (!rst) begin
      if (f) begin
        m_run++;
        if (m_run >= TO) m_err = 1;
        if (m_frz < MAXC) m_frz++;
      end else begin
        m_run = 0;
      end
      if (!f && lu && m_bub < MAXC) m_bub++;
      if (!f && !lu && br && m_fl < MAXC) m_fl++;
      m_waiting = m_waiting ? !ack : (mrq && !ack);
    end
    #2;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #2;
    do_reset();
    idle();

    // Load-use on rs2, then the bubble sits in EX.
    cyc(0, 0, 0, 1, 5'd5, 5'd0, 5'd5, 0);
    cyc(0, 0, 0, 0, 5'd5, 5'd0, 5'd5, 0);
    chk("bubble_one", {29'd0, bubble_cnt_o}, 32'd1);
    // Load into x0 never stalls.
    cyc(0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0);
    idle();

    // Freeze with ack on the 4th request cycle, then confirm release to RUN.
    do_reset();
    repeat (3) cyc(0, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, 0, 0);
    idle();
    chk("freeze_three", {29'd0, freeze_cnt_o}, 32'd3);
    chk("run_after_ack", {31'd0, PCWrite_o}, 32'd1);

    // Freeze dominates load-use and branch; then one bubble, then one flush.
    do_reset();
    repeat (2) cyc(0, 1, 0, 1, 5'd7, 5'd7, 5'd1, 1);
    cyc(0, 1, 1, 1, 5'd7, 5'd7, 5'd1, 1);
    cyc(0, 0, 0, 0, 5'd7, 5'd7, 5'd1, 1);
    idle();
    chk("prio_bubble", {29'd0, bubble_cnt_o}, 32'd1);
    chk("prio_flush",  {29'd0, flush_cnt_o},  32'd1);

    // Timeout, request dropped while waiting, late ack keeps the error.
    do_reset();
    repeat (4) cyc(0, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    idle();
    chk("err_sticky", {31'd0, mem_err_o}, 32'd1);
    // Reset mid-freeze.
    repeat (2) cyc(0, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    chk("rst_err_clear", {31'd0, mem_err_o}, 32'd0);
    idle();

    // Flush counter saturation.
    do_reset();
    repeat (MAXC + 2) cyc(0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    chk("flush_sat", {29'd0, flush_cnt_o}, MAXC);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic r_rst, r_mrq, r_ack, r_mr, r_br;
      logic [4:0] r_rd, r_rs1, r_rs2;
      r_rst = ($urandom_range(0, 59) == 0);
      r_mrq = ($urandom_range(0, 2) == 0);
      r_ack = ($urandom_range(0, 4) == 0);
      r_mr  = $urandom_range(0, 1);
      r_br  = ($urandom_range(0, 3) == 0);
      r_rd  = 5'($urandom_range(0, 3));
      r_rs1 = 5'($urandom_range(0, 3));
      r_rs2 = 5'($urandom_range(0, 3));
      cyc(r_rst, r_mrq, r_ack, r_mr, r_rd, r_rs1, r_rs2, r_br);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end
endmodule
